// File: rtl/alu_result_queue_pkg.sv
// alu_result_queue_pkg: shared opcodes, flag indices, entry layout and flag derivation
// Used by alu_result_queue; no ports.
package alu_result_queue_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_EQ  = 3'b101;
    localparam logic [2:0] OP_GT  = 3'b110;
    localparam logic [2:0] OP_LT  = 3'b111;
    localparam int FLG_ZERO = 0;
    localparam int FLG_CMP  = 1;
    localparam int FLG_DIV0 = 2;
    typedef struct packed {
        logic [15:0] result;
        logic [2:0]  opcode;
        logic [2:0]  flags;
    } entry_t;
    function automatic logic [2:0] calc_flags(input logic [2:0] op, input logic [15:0] res,
                                              input logic b_zero);
        calc_flags           = '0;
        calc_flags[FLG_ZERO] = res == 16'h0000;
        calc_flags[FLG_CMP]  = op == OP_EQ || op == OP_GT || op == OP_LT;
        calc_flags[FLG_DIV0] = b_zero && (op == OP_DIV || op == OP_MOD);
    endfunction
endpackage

// File: rtl/alu_result_queue_fifo.sv
// result_fifo: generic DEPTH x WIDTH synchronous FIFO with internal occupancy count
// Ports: clk, rst_n (async active-low), wr_en/wr_data push side, rd_en pop side,
//        rd_data head entry (zero while empty), full, empty.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    // Storage is left unreset, so the head is masked to keep outputs at zero while empty.
    assign rd_data = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/alu_result_queue.sv
// alu_result_queue: ALU writeback queue with flag derivation and div0 event counter
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_opcode/in_result/in_b_zero
//        producer side; out_valid/out_ready/out_result/out_opcode/out_flags consumer side;
//        div0_count saturating debug counter, clr_count synchronous clear.
module alu_result_queue
    import alu_result_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [15:0]      in_result,
    input  logic             in_b_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [2:0]       out_opcode,
    output logic [2:0]       out_flags,
    output logic [CNT_W-1:0] div0_count,
    input  logic             clr_count
);
    entry_t in_entry, head;
    logic   full, empty, push;
    assign in_entry  = '{result: in_result, opcode: in_opcode,
                         flags: calc_flags(in_opcode, in_result, in_b_zero)};
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign out_result = head.result;
    assign out_opcode = head.opcode;
    assign out_flags  = head.flags;
    result_fifo #(.DEPTH(DEPTH), .WIDTH($bits(entry_t))) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_valid),
        .wr_data (in_entry),
        .rd_en   (out_ready),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div0_count <= '0;
        else if (clr_count) div0_count <= '0;
        else if (push && in_entry.flags[FLG_DIV0] && div0_count != '1)
            div0_count <= div0_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue: directed self-checking bench for alu_result_queue
module tb_alu_result_queue;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_b_zero = 0, out_ready = 0, clr_count = 0;
    logic [2:0]  in_opcode = 0;
    logic [15:0] in_result = 0;
    logic        in_ready, out_valid;
    logic [15:0] out_result;
    logic [2:0]  out_opcode, out_flags;
    logic [7:0]  div0_count;
    int checks = 0, errors = 0;

    alu_result_queue #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_result(in_result), .in_b_zero(in_b_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_opcode(out_opcode), .out_flags(out_flags), .div0_count(div0_count),
        .clr_count(clr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [2:0] op, input logic [15:0] res, input logic bz);
        in_valid = 1; in_opcode = op; in_result = res; in_b_zero = bz;
        step();
        in_valid = 0; in_b_zero = 0;
    endtask

    task automatic pop1;
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    initial begin
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_div0_count", div0_count, 0);
        rst_n = 1;
        step();

        push1(3'b000, 16'h0005, 0);
        chk("first_valid", out_valid, 1);
        chk("first_result", out_result, 16'h0005);
        chk("first_flags", out_flags, 3'b000);
        chk("first_opcode", out_opcode, 3'b000);
        chk("first_ready", in_ready, 1);
        pop1();
        chk("first_drained", out_valid, 0);

        for (int i = 1; i <= 4; i++) push1(3'b000, 16'(i), 0);
        chk("full_in_ready", in_ready, 0);
        in_valid = 1; in_result = 16'h0009;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_hold_ready", in_ready, 0);
            chk("full_hold_head", out_result, 16'h0001);
        end
        in_valid = 0;
        out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_order", out_result, 16'(i));
            step();
            if (i == 1) chk("ready_after_pop", in_ready, 1);
        end
        chk("drain_empty", out_valid, 0);
        out_ready = 0;

        push1(3'b011, 16'h0000, 1);
        chk("div_flags", out_flags, 3'b101);
        chk("div_count1", div0_count, 1);
        pop1();
        push1(3'b001, 16'h0000, 1);
        chk("sub_bz_flags", out_flags, 3'b001);
        chk("sub_bz_count", div0_count, 1);
        pop1();
        push1(3'b101, 16'h0001, 0);
        chk("eq_flags", out_flags, 3'b010);
        pop1();
        push1(3'b111, 16'h0000, 0);
        chk("lt_flags", out_flags, 3'b011);
        chk("lt_opcode", out_opcode, 3'b111);
        pop1();

        push1(3'b000, 16'h0100, 0);
        push1(3'b000, 16'h0101, 0);
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            in_result = 16'h0102 + 16'(i);
            chk("stream_order", out_result, 16'h0100 + 16'(i));
            step();
            chk("stream_ready", in_ready, 1);
        end
        in_valid = 0;
        chk("stream_tail0", out_result, 16'h010A);
        step();
        chk("stream_tail1", out_result, 16'h010B);
        step();
        chk("stream_empty", out_valid, 0);

        in_valid = 1; in_opcode = 3'b011; in_result = 0; in_b_zero = 1;
        for (int i = 0; i < 300; i++) step();
        chk("div0_saturate", div0_count, 8'hFF);
        clr_count = 1;
        step();
        chk("clr_priority", div0_count, 0);
        clr_count = 0; in_valid = 0; in_b_zero = 0;
        step();
        chk("div0_drained", out_valid, 0);
        out_ready = 0;

        push1(3'b000, 16'h0031, 0);
        push1(3'b000, 16'h0032, 0);
        push1(3'b000, 16'h0033, 0);
        chk("pre_rst_valid", out_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_result", out_result, 0);
        step();
        rst_n = 1;
        push1(3'b010, 16'h0077, 0);
        chk("post_rst_result", out_result, 16'h0077);
        chk("post_rst_valid", out_valid, 1);
        pop1();
        chk("post_rst_alone", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
